// File: rtl/wb_fasm_bridge.sv
// Wishbone classic slave front-end for the FASM register bank: writes become a
// one-cycle FASM write strobe, reads wait a fixed latency before capturing rd_data.
//
// state   | meaning
// IDLE    | waiting for cyc_i & stb_i
// WR_ACK  | write strobe and ack asserted for one cycle
// RD_WAIT | read address registered, counting down the read latency
// RD_ACK  | read data captured, ack asserted for one cycle
module wb_fasm_bridge #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] adr_wr,
  output logic [DATA_WIDTH-1:0] adr_rd,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

  state_t          state;
  logic [CW-1:0]   lat_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ack_o   <= 1'b0;
      we      <= 1'b0;
      adr_wr  <= '0;
      adr_rd  <= '0;
      din     <= '0;
      dat_o   <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            if (we_i) begin
              adr_wr <= adr_i;
              din    <= dat_i;
              we     <= 1'b1;
              ack_o  <= 1'b1;
              state  <= WR_ACK;
            end else begin
              adr_rd  <= adr_i;
              lat_cnt <= LAT_LOAD;
              state   <= RD_WAIT;
            end
          end
        end
        WR_ACK: begin
          we    <= 1'b0;
          ack_o <= 1'b0;
          state <= IDLE;
        end
        RD_WAIT: begin
          // an abort wins over a read that would complete on this edge
          if (!cyc_i) begin
            state <= IDLE;
          end else if (lat_cnt == '0) begin
            dat_o <= rd_data;
            ack_o <= 1'b1;
            state <= RD_ACK;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RD_ACK: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fasm_bridge.sv
// Directed bench for wb_fasm_bridge: one bridge with READ_LATENCY=2 and one with
// READ_LATENCY=4, each driving a small FASM register-bank model.
module tb_wb_fasm_bridge;

  logic clk;
  logic reset;

  logic       cyc_a, stb_a, wei_a, ack_a, we_a;
  logic [7:0] adr_a, dati_a, dato_a, adr_wr_a, adr_rd_a, din_a, rd_data_a;
  logic       cyc_b, stb_b, wei_b, ack_b, we_b;
  logic [7:0] adr_b, dati_b, dato_b, adr_wr_b, adr_rd_b, din_b, rd_data_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] r1_a;
  logic [7:0] p1_b, p2_b, p3_b;
  int         ack_cnt_a;
  int         ack_snap;
  int         total;
  int         passed;
  int         failed;

  wb_fasm_bridge #(.DATA_WIDTH(8), .READ_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(wei_a),
    .adr_i(adr_a), .dat_i(dati_a), .dat_o(dato_a), .ack_o(ack_a), .we(we_a),
    .adr_wr(adr_wr_a), .adr_rd(adr_rd_a), .din(din_a), .rd_data(rd_data_a)
  );

  wb_fasm_bridge #(.DATA_WIDTH(8), .READ_LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(wei_b),
    .adr_i(adr_b), .dat_i(dati_b), .dat_o(dato_b), .ack_o(ack_b), .we(we_b),
    .adr_wr(adr_wr_b), .adr_rd(adr_rd_b), .din(din_b), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FASM register banks; read data is pipelined so it is only valid at the
  // READ_LATENCY edge, earlier it still shows the previous address' value
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'(i) ^ 8'h5A;
        mem_b[i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      if (we_a) mem_a[adr_wr_a] <= din_a;
      if (we_b) mem_b[adr_wr_b] <= din_b;
    end
    r1_a <= mem_a[adr_rd_a];
    p1_b <= mem_b[adr_rd_b];
    p2_b <= p1_b;
    p3_b <= p2_b;
    if (ack_a === 1'b1) ack_cnt_a <= ack_cnt_a + 1;
  end

  assign rd_data_a = r1_a;
  assign rd_data_b = p3_b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; passed = 0; failed = 0; ack_cnt_a = 0;
    cyc_b = 1'b0; stb_b = 1'b0; wei_b = 1'b0; adr_b = 8'h00; dati_b = 8'h00;

    // reset held for two cycles with a write request already present
    reset = 1'b1;
    cyc_a = 1'b1; stb_a = 1'b1; wei_a = 1'b1; adr_a = 8'h12; dati_a = 8'hA5;
    step();
    chk1("rst_ack", ack_a, 1'b0);
    chk1("rst_we", we_a, 1'b0);
    chk("rst_adr_wr", adr_wr_a, 8'h00);
    chk("rst_adr_rd", adr_rd_a, 8'h00);
    chk("rst_din", din_a, 8'h00);
    chk("rst_dat_o", dato_a, 8'h00);
    chk1("rst_ack_b", ack_b, 1'b0);
    step();
    chk1("rst2_ack", ack_a, 1'b0);
    chk1("rst2_we", we_a, 1'b0);
    reset = 1'b0;

    // write 0xA5 to 0x12, accepted at the first edge out of reset
    step();
    chk1("wr_we", we_a, 1'b1);
    chk1("wr_ack", ack_a, 1'b1);
    chk("wr_adr_wr", adr_wr_a, 8'h12);
    chk("wr_din", din_a, 8'hA5);
    cyc_a = 1'b0; stb_a = 1'b0;
    step();
    chk1("wr_we_low", we_a, 1'b0);
    chk1("wr_ack_low", ack_a, 1'b0);
    chk("wr_reg12", mem_a[8'h12], 8'hA5);
    chk("wr_reg13", mem_a[8'h13], 8'h49);

    // read 0x12 with READ_LATENCY=2
    cyc_a = 1'b1; stb_a = 1'b1; wei_a = 1'b0; adr_a = 8'h12;
    step();
    chk("rd_adr_rd", adr_rd_a, 8'h12);
    chk1("rd_ack_c1", ack_a, 1'b0);
    step();
    chk1("rd_ack_c2", ack_a, 1'b0);
    step();
    chk1("rd_ack_c3", ack_a, 1'b1);
    chk("rd_dat_o", dato_a, 8'hA5);
    cyc_a = 1'b0; stb_a = 1'b0;
    step();
    chk1("rd_ack_c4", ack_a, 1'b0);
    chk("rd_dat_hold", dato_a, 8'hA5);

    // back-to-back writes with stb held high
    ack_snap = ack_cnt_a;
    cyc_a = 1'b1; stb_a = 1'b1; wei_a = 1'b1; adr_a = 8'h01; dati_a = 8'h11;
    step();
    chk1("b2b_we_c1", we_a, 1'b1);
    chk("b2b_adr_c1", adr_wr_a, 8'h01);
    chk("b2b_din_c1", din_a, 8'h11);
    adr_a = 8'h02; dati_a = 8'h22;
    step();
    chk1("b2b_we_c2", we_a, 1'b0);
    step();
    chk1("b2b_we_c3", we_a, 1'b1);
    chk("b2b_adr_c3", adr_wr_a, 8'h02);
    chk("b2b_din_c3", din_a, 8'h22);
    cyc_a = 1'b0; stb_a = 1'b0;
    step();
    chk1("b2b_we_c4", we_a, 1'b0);
    chk("b2b_acks", 8'(ack_cnt_a - ack_snap), 8'd2);
    chk("b2b_reg01", mem_a[8'h01], 8'h11);
    chk("b2b_reg02", mem_a[8'h02], 8'h22);

    // READ_LATENCY=4: completed read of 0x07 sets dat_o to 0x5D
    cyc_b = 1'b1; stb_b = 1'b1; wei_b = 1'b0; adr_b = 8'h07;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk1("rd4_noack", ack_b, 1'b0);
    end
    step();
    chk1("rd4_ack", ack_b, 1'b1);
    chk("rd4_dat_o", dato_b, 8'h5D);
    cyc_b = 1'b0; stb_b = 1'b0;
    step();
    chk1("rd4_ack_low", ack_b, 1'b0);

    // abort a read of 0x09 after two cycles, then a write one cycle later
    cyc_b = 1'b1; stb_b = 1'b1; wei_b = 1'b0; adr_b = 8'h09;
    step();
    chk1("abt_ack_c1", ack_b, 1'b0);
    step();
    chk1("abt_ack_c2", ack_b, 1'b0);
    cyc_b = 1'b0; stb_b = 1'b0;
    step();
    chk1("abt_ack_c3", ack_b, 1'b0);
    chk("abt_dat_hold", dato_b, 8'h5D);
    cyc_b = 1'b1; stb_b = 1'b1; wei_b = 1'b1; adr_b = 8'h0A; dati_b = 8'h77;
    step();
    chk1("abt_wr_we", we_b, 1'b1);
    chk1("abt_wr_ack", ack_b, 1'b1);
    chk("abt_wr_adr", adr_wr_b, 8'h0A);
    chk("abt_wr_din", din_b, 8'h77);
    cyc_b = 1'b0; stb_b = 1'b0;
    step();
    chk1("abt_wr_we_low", we_b, 1'b0);
    chk("abt_reg0a", mem_b[8'h0A], 8'h77);
    chk("abt_dat_final", dato_b, 8'h5D);

    // reset during RD_WAIT drops the read
    cyc_a = 1'b1; stb_a = 1'b1; wei_a = 1'b0; adr_a = 8'h02;
    step();
    chk("rr_adr_rd", adr_rd_a, 8'h02);
    reset = 1'b1;
    step();
    chk1("rr_ack", ack_a, 1'b0);
    chk1("rr_we", we_a, 1'b0);
    chk("rr_adr_rd0", adr_rd_a, 8'h00);
    chk("rr_adr_wr0", adr_wr_a, 8'h00);
    chk("rr_din0", din_a, 8'h00);
    chk("rr_dat_o0", dato_a, 8'h00);
    reset = 1'b0;
    cyc_a = 1'b0; stb_a = 1'b0;
    step();
    chk1("rr_ack_after", ack_a, 1'b0);
    cyc_a = 1'b1; stb_a = 1'b1; wei_a = 1'b1; adr_a = 8'h33; dati_a = 8'h3C;
    step();
    chk1("rr_idle_we", we_a, 1'b1);
    chk("rr_idle_adr", adr_wr_a, 8'h33);
    cyc_a = 1'b0; stb_a = 1'b0;
    step();
    chk1("rr_idle_we_low", we_a, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_fasm_bridge.md
# wb_fasm_bridge

Wishbone classic slave front-end for the FASM register bank. It accepts single Wishbone read and write cycles and turns each write into a one-cycle FASM write strobe with registered address and data. It turns each read into a registered read address, waits a fixed read latency, captures the read mux output and acknowledges. The FASM register instances sit directly downstream, and their data_reg outputs are muxed back into rd_data.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of data and of FASM addresses.
- READ_LATENCY, default 1: cycles from adr_rd update to valid rd_data. Legal range is 1..15.

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- cyc_i, in, 1: Wishbone cycle.
- stb_i, in, 1: Wishbone strobe.
- we_i, in, 1: Wishbone write enable.
- adr_i, in, DATA_WIDTH: Wishbone address.
- dat_i, in, DATA_WIDTH: Wishbone write data.
- dat_o, out, DATA_WIDTH: Wishbone read data.
- ack_o, out, 1: Wishbone acknowledge.
- we, out, 1: FASM write strobe.
- adr_wr, out, DATA_WIDTH: FASM write address.
- adr_rd, out, DATA_WIDTH: FASM read address.
- din, out, DATA_WIDTH: FASM write data.
- rd_data, in, DATA_WIDTH: muxed FASM register read-back.

## Operation
- Reset, sampled at a clk edge with reset=1:
  - state goes to IDLE.
  - ack_o, we, adr_wr, adr_rd, din and dat_o all go to 0.
  - The latency counter goes to 0.
  - Reset dominates every other input in the same cycle.
  - Reset mid-read drops the transfer; no ack is issued.
- A request is cyc_i & stb_i, sampled only in IDLE. Inputs are ignored in all other states.
- State machine:
  - IDLE, request with we_i=1: register adr_wr<=adr_i, din<=dat_i, we<=1, ack_o<=1. Go to WR_ACK.
  - IDLE, request with we_i=0: register adr_rd<=adr_i, load counter with READ_LATENCY-1. Go to RD_WAIT.
  - WR_ACK: we<=0, ack_o<=0. Go to IDLE.
  - RD_WAIT, cyc_i=0 (abort): go to IDLE; no ack; dat_o unchanged.
  - RD_WAIT, counter=0: dat_o<=rd_data, ack_o<=1. Go to RD_ACK.
  - RD_WAIT, counter≠0: decrement the counter and stay.
  - RD_ACK: ack_o<=0. Go to IDLE.
- Holding values:
  - adr_wr, din and adr_rd hold their last values between transfers and are not cleared.
  - dat_o holds until the next completed read.
- Exactly one ack is issued per accepted, non-aborted request.
- Writes cannot be aborted: they complete in one cycle, and cyc_i dropping during WR_ACK has no effect.
- Back-to-back transfers:
  - If the master keeps cyc_i & stb_i high after an ack, the next request is sampled in the IDLE cycle that follows.
  - The minimum spacing is therefore 2 cycles per write and READ_LATENCY+2 cycles per read.
- The bridge does no address decode; every request is acked. Downstream FASM registers compare adr_wr themselves.

## Timing
- Let E0 be the edge at which a request is accepted in IDLE.
- Write:
  - we=1, ack_o=1, adr_wr and din are valid in the cycle after E0.
  - The FASM register captures din at E1.
  - we is high for exactly 1 cycle.
- Read:
  - adr_rd is valid from E0.
  - rd_data is sampled at edge E(READ_LATENCY).
  - ack_o=1 with valid dat_o in the cycle after E(READ_LATENCY).
  - With READ_LATENCY=1, ack_o appears in the cycle after E1.
- Abort: cyc_i=0 sampled at any RD_WAIT edge returns the bridge to IDLE at that edge. A request present in that same cycle is not accepted; it is sampled in the next cycle.
- All outputs are registered; there is no combinational path from the Wishbone inputs to any output.

## Test plan
- Reset: drive reset=1 for 2 cycles with cyc_i=stb_i=1 → all outputs are 0 and no ack is issued. Release reset → the request is accepted at the first edge with reset=0.
- Write: DATA_WIDTH=8, write adr_i=0x12, dat_i=0xA5 → in the cycle after E0, we=1, adr_wr=0x12, din=0xA5 and ack_o=1. we=0 in the next cycle. A FASM_register with REG_ADDR=0x12 then reads 0xA5, and one with REG_ADDR=0x13 is unchanged.
- Read, READ_LATENCY=2: rd_data follows adr_rd=0x12 with a 2-cycle delay and returns 0xA5 → adr_rd=0x12 after E0. ack_o=1 with dat_o=0xA5 exactly 3 cycles after E0, for exactly 1 cycle.
- Back-to-back: hold stb_i high for a write to 0x01 (0x11) then a write to 0x02 (0x22) → we pulses in cycles 1 and 3. Exactly two acks are issued, and the registers at 0x01 and 0x02 hold 0x11 and 0x22.
- Abort: READ_LATENCY=4, start a read, then drop cyc_i after 2 cycles → no ack is issued, dat_o keeps its prior value, and a new write accepted 1 cycle later completes normally.
- Reset mid-read: assert reset during RD_WAIT → ack_o stays 0, all outputs are 0 in the next cycle, and the state is IDLE.
